// File: rtl/minimal_dma_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : minimal_dma_cmd_gen
// Brief    : Splits a DMA transfer into boundary-safe datamover burst commands.
//            Optional irq pulse on completion: define MINIMAL_DMA_CMD_IRQ_EN.
// Revision : 1.0
// ============================================================================
module minimal_dma_cmd_gen #(
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 23,
  parameter int MAX_BURST_BYTES = 4096,
  parameter int TAG_W           = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic                               cfg_start,
  input  logic                               cfg_abort,
  input  logic [ADDR_W-1:0]                  cfg_addr,
  input  logic [LEN_W-1:0]                   cfg_len,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [ADDR_W-1:0]                  cmd_addr,
  output logic [$clog2(MAX_BURST_BYTES):0]   cmd_btt,
  output logic [TAG_W-1:0]                   cmd_tag,
  output logic                               cmd_last,
  input  logic                               sts_valid,
  input  logic                               sts_ok,
  output logic                               sts_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic                               irq
);

  localparam int c_MB_LOG = $clog2(MAX_BURST_BYTES);
  localparam int c_BTT_W  = c_MB_LOG + 1;
  localparam int c_CMP_W  = (LEN_W > c_BTT_W) ? LEN_W : c_BTT_W;
  // Enough for the worst-case command count of one transfer, plus headroom.
  localparam int c_OUT_W  = ((LEN_W > c_MB_LOG) ? (LEN_W - c_MB_LOG) : 0) + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [LEN_W-1:0]     r_rem;
  logic [TAG_W-1:0]     r_tag;
  logic [c_OUT_W-1:0]   r_out_cnt;
  logic                 r_stop;
  logic                 r_done;
  logic                 r_err;

  logic [c_BTT_W-1:0]   w_room;
  logic [c_CMP_W-1:0]   w_rem_ext;
  logic [c_CMP_W-1:0]   w_room_ext;
  logic [c_CMP_W-1:0]   w_btt_ext;
  logic                 w_last;
  logic                 w_cmd_hs;
  logic                 w_sts_acc;
  logic                 w_start_acc;
  logic                 w_stop_req;
  logic                 w_done_entry;

  // Bytes left before the next MAX_BURST_BYTES-aligned boundary.
  assign w_room     = c_BTT_W'(MAX_BURST_BYTES) - {1'b0, r_addr[c_MB_LOG-1:0]};
  assign w_rem_ext  = c_CMP_W'(r_rem);
  assign w_room_ext = c_CMP_W'(w_room);
  assign w_last     = (w_rem_ext <= w_room_ext);
  assign w_btt_ext  = w_last ? w_rem_ext : w_room_ext;

  assign cmd_valid  = (r_state == S_ISSUE);
  assign cmd_addr   = r_addr;
  assign cmd_btt    = c_BTT_W'(w_btt_ext);
  assign cmd_tag    = r_tag;
  assign cmd_last   = cmd_valid & w_last;
  assign sts_ready  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign busy       = sts_ready;
  assign done       = r_done;
  assign err        = r_err;

  assign w_cmd_hs     = cmd_valid & cmd_ready;
  assign w_sts_acc    = sts_valid & sts_ready & (r_out_cnt != '0);
  assign w_start_acc  = (r_state == S_IDLE) & cfg_start;
  assign w_stop_req   = cfg_abort | (w_sts_acc & ~sts_ok);
  assign w_done_entry = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_state_nxt = (cfg_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A presented command is never retracted; stopping waits for its handshake.
        if (w_cmd_hs && (w_last || r_stop || w_stop_req)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_out_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_tag     <= '0;
      r_out_cnt <= '0;
      r_stop    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_addr <= cfg_addr;
        r_rem  <= cfg_len;
      end else if (w_cmd_hs) begin
        r_addr <= r_addr + ADDR_W'(cmd_btt);
        r_rem  <= r_rem - LEN_W'(cmd_btt);
      end

      if (w_cmd_hs) begin
        r_tag <= r_tag + TAG_W'(1);
      end

      case ({w_cmd_hs, w_sts_acc})
        2'b10:   r_out_cnt <= r_out_cnt + c_OUT_W'(1);
        2'b01:   r_out_cnt <= r_out_cnt - c_OUT_W'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase

      if (w_start_acc) begin
        r_stop <= 1'b0;
      end else if ((r_state == S_ISSUE) && w_stop_req) begin
        r_stop <= 1'b1;
      end

      if (w_start_acc) begin
        r_err <= 1'b0;
      end else if (w_sts_acc && !sts_ok) begin
        r_err <= 1'b1;
      end

      if (w_done_entry) begin
        r_done <= 1'b1;
      end else if (w_start_acc) begin
        r_done <= 1'b0;
      end
    end
  end

`ifdef MINIMAL_DMA_CMD_IRQ_EN
  logic r_irq;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_done_entry;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_minimal_dma_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_minimal_dma_cmd_gen
// Brief    : Directed self-checking bench for minimal_dma_cmd_gen.
// Revision : 1.0
// ============================================================================
module tb_minimal_dma_cmd_gen;

`ifdef MINIMAL_DMA_CMD_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic        tb_ACLK   = 1'b0;
  logic        tb_ARESET = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_addr  = '0;
  logic [22:0] cfg_len   = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [12:0] cmd_btt;
  logic [3:0]  cmd_tag;
  logic        cmd_last;
  logic        sts_valid = 1'b0;
  logic        sts_ok    = 1'b1;
  logic        sts_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;
  int irq_cnt  = 0;
  int irq_base = 0;

  logic [31:0] hs_addr[$];
  logic [12:0] hs_btt[$];
  logic [3:0]  hs_tag[$];
  logic        hs_last[$];

  logic [31:0] exp_addr [4] = '{32'h0000_0F00, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  logic [12:0] exp_btt  [4] = '{13'h0100, 13'h1000, 13'h1000, 13'h0100};

  minimal_dma_cmd_gen #(
    .ADDR_W          (32),
    .LEN_W           (23),
    .MAX_BURST_BYTES (4096),
    .TAG_W           (4)
  ) dut (
    .ACLK      (tb_ACLK),
    .ARESET    (tb_ARESET),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .cfg_addr  (cfg_addr),
    .cfg_len   (cfg_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_btt   (cmd_btt),
    .cmd_tag   (cmd_tag),
    .cmd_last  (cmd_last),
    .sts_valid (sts_valid),
    .sts_ok    (sts_ok),
    .sts_ready (sts_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .irq       (irq)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  // Inputs change just after rising edges, so the falling edge sees the values the next edge will use.
  always @(negedge tb_ACLK) begin
    if (cmd_valid && cmd_ready) begin
      hs_addr.push_back(cmd_addr);
      hs_btt.push_back(cmd_btt);
      hs_tag.push_back(cmd_tag);
      hs_last.push_back(cmd_last);
    end
    if (irq) irq_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [22:0] l);
    hs_addr.delete();
    hs_btt.delete();
    hs_tag.delete();
    hs_last.delete();
    irq_base  = irq_cnt;
    cfg_addr  = a;
    cfg_len   = l;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int b = 0;
    while (hs_addr.size() < n && b < 50) begin
      step();
      b++;
    end
    check("hs_count", 64'(hs_addr.size()), 64'(n));
  endtask

  task automatic check_hs(input int i, input logic [31:0] a, input logic [12:0] btt,
                          input logic [3:0] tag, input logic last);
    check("hs_addr", hs_addr[i], a);
    check("hs_btt", hs_btt[i], btt);
    check("hs_tag", hs_tag[i], tag);
    check("hs_last", hs_last[i], last);
  endtask

  task automatic send_sts(input logic ok);
    sts_valid = 1'b1;
    sts_ok    = ok;
    step();
    sts_valid = 1'b0;
    sts_ok    = 1'b1;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int b = 0;
    while (done !== 1'b1 && b < 50) begin
      step();
      b++;
    end
    check(tag, done, 1'b1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy"}, busy, 1'b0);
    step();
    check({tag, "_irq_count"}, 64'(irq_cnt - irq_base), 64'(IRQ_EXP));
    check({tag, "_done_sticky"}, done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("reset_outputs", {cmd_valid, cmd_addr, cmd_btt, cmd_tag, cmd_last,
                            sts_ready, busy, done, err, irq}, 64'h0);
    tb_ARESET = 1'b0;
    step();

    // Single command inside one burst window
    cmd_ready = 1'b1;
    start_xfer(32'h0000_1000, 23'h100);
    check("t1_valid", cmd_valid, 1'b1);
    check("t1_addr", cmd_addr, 32'h0000_1000);
    check("t1_btt", cmd_btt, 13'h100);
    check("t1_tag", cmd_tag, 4'd0);
    check("t1_last", cmd_last, 1'b1);
    check("t1_busy", busy, 1'b1);
    step();
    check("t1_hs_count", 64'(hs_addr.size()), 64'd1);
    check("t1_valid_drop", cmd_valid, 1'b0);
    check("t1_sts_ready", sts_ready, 1'b1);
    send_sts(1'b1);
    wait_done("t1_done", 1'b0);

    // Boundary splitting, back-to-back commands
    start_xfer(32'h0000_0F00, 23'h2200);
    check("t2_done_cleared", done, 1'b0);
    wait_hs(4);
    for (int i = 0; i < 4; i++) check_hs(i, exp_addr[i], exp_btt[i], 4'(1 + i), (i == 3));
    repeat (4) send_sts(1'b1);
    wait_done("t2_done", 1'b0);

    // Back-pressure: outputs must hold while cmd_ready is low
    cmd_ready = 1'b0;
    start_xfer(32'h0000_0F00, 23'h2200);
    check("t3_first_addr", cmd_addr, 32'h0000_0F00);
    check("t3_first_tag", cmd_tag, 4'd5);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", cmd_valid, 1'b1);
      check("t3_stall_addr", cmd_addr, 32'h0000_1000);
      check("t3_stall_btt", cmd_btt, 13'h1000);
      check("t3_stall_tag", cmd_tag, 4'd6);
      step();
    end
    cmd_ready = 1'b1;
    wait_hs(4);
    repeat (3) step();
    check("t3_no_dup", 64'(hs_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_hs(i, exp_addr[i], exp_btt[i], 4'(5 + i), (i == 3));
    repeat (4) send_sts(1'b1);
    wait_done("t3_done", 1'b0);

    // Error status on the 2nd return stops issuing after the pending command
    cmd_ready = 1'b1;
    start_xfer(32'h0000_0F00, 23'h2200);
    step();
    step();
    cmd_ready = 1'b0;
    send_sts(1'b1);
    send_sts(1'b0);
    check("t4_err", err, 1'b1);
    check("t4_pending_valid", cmd_valid, 1'b1);
    check("t4_pending_addr", cmd_addr, 32'h0000_2000);
    check("t4_pending_tag", cmd_tag, 4'd11);
    cmd_ready = 1'b1;
    step();
    check("t4_valid_drop", cmd_valid, 1'b0);
    repeat (3) step();
    check("t4_hs_count", 64'(hs_addr.size()), 64'd3);
    check_hs(2, 32'h0000_2000, 13'h1000, 4'd11, 1'b0);
    check("t4_busy_draining", busy, 1'b1);
    check("t4_not_done", done, 1'b0);
    send_sts(1'b1);
    wait_done("t4_done", 1'b1);

    // Zero-length transfer completes immediately and clears err
    start_xfer(32'h0000_4000, 23'h0);
    check("t5_no_valid", cmd_valid, 1'b0);
    wait_done("t5_done", 1'b0);
    check("t5_no_cmds", 64'(hs_addr.size()), 64'd0);

    // Abort during ISSUE
    cmd_ready = 1'b1;
    start_xfer(32'h0000_0F00, 23'h2200);
    step();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("t6_valid_drop", cmd_valid, 1'b0);
    check("t6_busy", busy, 1'b1);
    repeat (3) step();
    check("t6_hs_count", 64'(hs_addr.size()), 64'd2);
    check_hs(1, 32'h0000_1000, 13'h1000, 4'd13, 1'b0);
    repeat (2) send_sts(1'b1);
    wait_done("t6_done", 1'b0);

    // Asynchronous reset in the middle of ISSUE
    cmd_ready = 1'b0;
    start_xfer(32'h0000_1000, 23'h100);
    check("t7_valid", cmd_valid, 1'b1);
    #2 tb_ARESET = 1'b1;
    #1;
    check("t7_reset_outputs", {cmd_valid, cmd_addr, cmd_btt, cmd_tag, cmd_last,
                               sts_ready, busy, done, err, irq}, 64'h0);
    @(posedge tb_ACLK);
    #1 tb_ARESET = 1'b0;
    step();

    // Address wrap across 2^32 after reset (tag restarts at 0)
    cmd_ready = 1'b1;
    start_xfer(32'hFFFF_FF00, 23'h200);
    wait_hs(2);
    check_hs(0, 32'hFFFF_FF00, 13'h100, 4'd0, 1'b0);
    check_hs(1, 32'h0000_0000, 13'h100, 4'd1, 1'b1);
    repeat (2) send_sts(1'b1);
    wait_done("t8_done", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
